// File: rtl/nl_writeback.sv
// Output writeback for the non-linearity stream: packs PACK words per line and writes
// consecutive output-buffer lines from a base address, masking the final partial line.
module nl_writeback #(
    parameter int WID    = 16,
    parameter int PACK   = 4,
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_start,
    input  logic [ADDR_W-1:0]     cfg_base_addr,
    input  logic [CNT_W-1:0]      cfg_num_words,
    input  logic                  in_valid,
    input  logic [WID-1:0]        in_data,
    output logic                  in_ready,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [PACK*WID-1:0]   wr_data,
    output logic [PACK-1:0]       wr_mask,
    output logic                  busy,
    output logic                  done
);

    localparam int LANE_W = $clog2(PACK);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PACK  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [LANE_W-1:0]    lane_p0;
    logic [CNT_W-1:0]     remain_p0;
    logic [ADDR_W-1:0]    line_addr_p0;
    logic [PACK*WID-1:0]  pack_p0;

    logic                 vld_p1;
    logic [ADDR_W-1:0]    addr_p1;
    logic [PACK*WID-1:0]  data_p1;
    logic [PACK-1:0]      mask_p1;

    logic accept;
    logic line_done;
    logic wr_hs;
    logic last_word;

    function automatic logic [PACK*WID-1:0] insert_word(
        input logic [PACK*WID-1:0] line,
        input logic [LANE_W-1:0]   lane,
        input logic [WID-1:0]      word
    );
        logic [PACK*WID-1:0] r;
        r = line;
        r[int'(lane)*WID +: WID] = word;
        return r;
    endfunction

    // Lanes 0..last are the ones holding words of this line.
    function automatic logic [PACK-1:0] fill_mask(input logic [LANE_W-1:0] last);
        logic [PACK-1:0] m;
        m = '0;
        for (int i = 0; i < PACK; i++) begin
            m[i] = (i <= int'(last));
        end
        return m;
    endfunction

    assign in_ready  = (state == S_PACK) && (!vld_p1 || wr_ready);
    assign accept    = in_valid && in_ready;
    assign last_word = (remain_p0 == CNT_W'(1));
    assign line_done = accept && ((lane_p0 == LANE_W'(PACK - 1)) || last_word);
    assign wr_hs     = vld_p1 && wr_ready;

    assign wr_valid = vld_p1;
    assign wr_addr  = addr_p1;
    assign wr_data  = data_p1;
    assign wr_mask  = mask_p1;
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (cfg_start) begin
                    state_nxt = (cfg_num_words != '0) ? S_PACK : S_DONE;
                end
            end
            S_PACK: begin
                if (accept && last_word) begin
                    state_nxt = S_DRAIN;
                end
            end
            // Only the final line can be pending here.
            S_DRAIN: begin
                if (wr_hs) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Stage p0: job counters and the line being packed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_p0      <= '0;
            remain_p0    <= '0;
            line_addr_p0 <= '0;
            pack_p0      <= '0;
        end else if (state == S_IDLE) begin
            if (cfg_start) begin
                lane_p0      <= '0;
                remain_p0    <= cfg_num_words;
                line_addr_p0 <= cfg_base_addr;
                pack_p0      <= '0;
            end
        end else if (accept) begin
            remain_p0 <= remain_p0 - CNT_W'(1);
            if (line_done) begin
                // Clearing the pack register keeps unfilled lanes of a partial line at zero.
                lane_p0      <= '0;
                pack_p0      <= '0;
                line_addr_p0 <= line_addr_p0 + ADDR_W'(1);
            end else begin
                lane_p0 <= lane_p0 + LANE_W'(1);
                pack_p0 <= insert_word(pack_p0, lane_p0, in_data);
            end
        end
    end

    // Stage p1: completed line held until the buffer takes it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            addr_p1 <= '0;
            data_p1 <= '0;
            mask_p1 <= '0;
        end else begin
            if (wr_hs) begin
                vld_p1 <= 1'b0;
            end
            if (line_done) begin
                vld_p1  <= 1'b1;
                addr_p1 <= line_addr_p0;
                data_p1 <= insert_word(pack_p0, lane_p0, in_data);
                mask_p1 <= fill_mask(lane_p0);
            end
        end
    end

endmodule

// File: tb/tb_nl_writeback.sv
// Directed bench for nl_writeback: expected lines queued per job, checked on each handshake.
module tb_nl_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_start;
    logic [11:0] cfg_base_addr;
    logic [15:0] cfg_num_words;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        wr_valid;
    logic        wr_ready;
    logic [11:0] wr_addr;
    logic [63:0] wr_data;
    logic [3:0]  wr_mask;
    logic        busy;
    logic        done;

    typedef struct {
        logic [11:0] a;
        logic [63:0] d;
        logic [3:0]  m;
    } line_t;

    line_t exp_q[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int wr_count = 0;
    int done_count = 0;
    int done_cyc = -1;
    int hs_cyc = -1;
    int max_wait = 0;

    nl_writeback #(.WID(16), .PACK(4), .ADDR_W(12), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .cfg_start(cfg_start), .cfg_base_addr(cfg_base_addr), .cfg_num_words(cfg_num_words),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_mask(wr_mask), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_line(input logic [11:0] a, input logic [63:0] d, input logic [3:0] m);
        line_t l;
        l.a = a;
        l.d = d;
        l.m = m;
        exp_q.push_back(l);
    endtask

    // Scoreboard side: every handshake pops one expected line.
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_valid && wr_ready) begin
                line_t l;
                wr_count++;
                hs_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {52'd0, wr_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    l = exp_q.pop_front();
                    check("wr_addr", {52'd0, wr_addr}, {52'd0, l.a});
                    check("wr_data", wr_data, l.d);
                    check("wr_mask", {60'd0, wr_mask}, {60'd0, l.m});
                end
            end
            if (done) begin
                done_count++;
                done_cyc = cyc;
            end
        end
    end

    task automatic start_job(input logic [11:0] base, input logic [15:0] num);
        cfg_base_addr = base;
        cfg_num_words = num;
        cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data = w;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 100) begin
                check("accept_timeout", 64'd0, 64'd1);
                break;
            end
        end
        if (n > max_wait) max_wait = n;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 50);
        check(tag, {63'd0, done}, 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, "_one_cycle"}, {63'd0, done}, 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int wc;
        int dc;
        rst = 1'b1;
        cfg_start = 1'b0;
        cfg_base_addr = '0;
        cfg_num_words = '0;
        in_valid = 1'b0;
        in_data = '0;
        wr_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_wr_valid", {63'd0, wr_valid}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_wr_addr", {52'd0, wr_addr}, 64'd0);
        check("rst_wr_data", wr_data, 64'd0);
        check("rst_wr_mask", {60'd0, wr_mask}, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Two full lines at full throughput
        max_wait = 0;
        push_line(12'h010, 64'h0004_0003_0002_0001, 4'hF);
        push_line(12'h011, 64'h0008_0007_0006_0005, 4'hF);
        start_job(12'h010, 16'd8);
        check("busy_after_start", {63'd0, busy}, 64'd1);
        for (int w = 1; w <= 8; w++) send_word(16'(w));
        wait_done("done_full");
        check("in_ready_no_drop", 64'(max_wait), 64'd0);
        check("done_after_hs", 64'(done_cyc), 64'(hs_cyc + 1));
        check("q_empty_full", 64'(exp_q.size()), 64'd0);
        check("busy_idle", {63'd0, busy}, 64'd0);

        // Partial final line
        wc = wr_count;
        push_line(12'h020, 64'h0004_0003_0002_0001, 4'hF);
        push_line(12'h021, 64'h0000_0000_0006_0005, 4'h3);
        start_job(12'h020, 16'd6);
        for (int w = 1; w <= 6; w++) send_word(16'(w));
        wait_done("done_partial");
        check("writes_partial", 64'(wr_count - wc), 64'd2);

        // Back-pressure: buffer stalls for 5 cycles with a line pending
        wr_ready = 1'b0;
        push_line(12'h100, 64'h00A4_00A3_00A2_00A1, 4'hF);
        push_line(12'h101, 64'h00A8_00A7_00A6_00A5, 4'hF);
        start_job(12'h100, 16'd8);
        for (int w = 1; w <= 4; w++) send_word(16'h00A0 + 16'(w));
        in_valid = 1'b1;
        in_data = 16'h00A5;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_in_ready", {63'd0, in_ready}, 64'd0);
            check("stall_wr_valid", {63'd0, wr_valid}, 64'd1);
            check("stall_wr_addr", {52'd0, wr_addr}, 64'h100);
            check("stall_wr_data", wr_data, 64'h00A4_00A3_00A2_00A1);
            check("stall_wr_mask", {60'd0, wr_mask}, 64'hF);
        end
        @(posedge clk); #1;
        wr_ready = 1'b1;
        for (int w = 5; w <= 8; w++) send_word(16'h00A0 + 16'(w));
        wait_done("done_stall");
        check("q_empty_stall", 64'(exp_q.size()), 64'd0);

        // Line address wraps
        push_line(12'hFFF, 64'h0014_0013_0012_0011, 4'hF);
        push_line(12'h000, 64'h0018_0017_0016_0015, 4'hF);
        start_job(12'hFFF, 16'd8);
        for (int w = 1; w <= 8; w++) send_word(16'h0010 + 16'(w));
        wait_done("done_wrap");
        check("q_empty_wrap", 64'(exp_q.size()), 64'd0);

        // Empty job
        wc = wr_count;
        start_job(12'h0AA, 16'd0);
        @(negedge clk);
        check("empty_done", {63'd0, done}, 64'd1);
        check("empty_wr_valid", {63'd0, wr_valid}, 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("empty_done_low", {63'd0, done}, 64'd0);
        check("empty_idle", {63'd0, busy}, 64'd0);
        check("empty_no_write", 64'(wr_count - wc), 64'd0);
        @(posedge clk); #1;

        // Start while busy is ignored
        wc = wr_count;
        push_line(12'h200, 64'h0024_0023_0022_0021, 4'hF);
        start_job(12'h200, 16'd4);
        start_job(12'h300, 16'd0);
        check("busy_ignore", {63'd0, busy}, 64'd1);
        for (int w = 1; w <= 4; w++) send_word(16'h0020 + 16'(w));
        wait_done("done_ignore");
        check("writes_ignore", 64'(wr_count - wc), 64'd1);

        // Reset in the middle of a line
        start_job(12'h040, 16'd4);
        send_word(16'h00C1);
        send_word(16'h00C2);
        dc = done_count;
        wc = wr_count;
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("mid_rst_busy", {63'd0, busy}, 64'd0);
        check("mid_rst_wr_valid", {63'd0, wr_valid}, 64'd0);
        check("mid_rst_done", {63'd0, done}, 64'd0);
        check("mid_rst_wr_mask", {60'd0, wr_mask}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_rst_no_done", 64'(done_count - dc), 64'd0);
        check("mid_rst_no_write", 64'(wr_count - wc), 64'd0);
        @(posedge clk); #1;
        push_line(12'h050, 64'h0034_0033_0032_0031, 4'hF);
        start_job(12'h050, 16'd4);
        for (int w = 1; w <= 4; w++) send_word(16'h0030 + 16'(w));
        wait_done("done_after_rst");
        check("q_empty_final", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
